// File: rtl/mem_pkg.sv
// mem_pkg: shared funct3 access codes, LSU state encoding and byte-enable width.
package mem_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam int BE_W = 4;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: data-memory request/acknowledge bus between the LSU and memory.
interface mem_stage_lsu_if;
    import mem_pkg::*;
    logic            dmem_req;
    logic            dmem_we;
    logic [31:0]     dmem_addr;
    logic [31:0]     dmem_wdata;
    logic [BE_W-1:0] dmem_be;
    logic [31:0]     dmem_rdata;
    logic            dmem_ack;
    modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, input dmem_rdata, dmem_ack);
    modport slave (input dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, output dmem_rdata, dmem_ack);
endinterface

// File: rtl/lsu_load_align.sv
// lsu_load_align: selects the addressed byte/half lane of a read word and sign/zero extends it.
module lsu_load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b = rdata[{addr, 3'b000} +: 8];
        h = addr[1] ? rdata[31:16] : rdata[15:0];
        result = funct3 == F3_B  ? {{24{b[7]}}, b} :
                 funct3 == F3_BU ? {24'h0, b} :
                 funct3 == F3_H  ? {{16{h[15]}}, h} :
                 funct3 == F3_HU ? {16'h0, h} : rdata;
    end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit; runs the dmem handshake, stalls the pipe while
// an access is outstanding, formats stores, aligns loads and resolves the branch decision.
module mem_stage_lsu
    import mem_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_memRead,
    input  logic               mem_memWrite,
    input  logic [31:0]        mem_ALUResult,
    input  logic [31:0]        mem_readData2,
    input  logic [2:0]         mem_funct3,
    input  logic               mem_branch,
    input  logic               mem_zeroFlag,
    input  logic [31:0]        mem_branchTargetAddress,
    mem_stage_lsu_if.master    dmem,
    output logic               stall,
    output logic [31:0]        load_data,
    output logic               misalign,
    output logic               bus_err,
    output logic               pcsrc,
    output logic [31:0]        branch_target
);
    state_t      state;
    logic [7:0]  cnt;
    logic [1:0]  lane;
    logic [2:0]  f3;
    logic [31:0] aligned;
    logic        access, is_b, is_h, bad, start;

    // funct3 encodings other than byte and half (incl. 011/110/111) behave as word
    assign access = mem_memRead | mem_memWrite;
    assign is_b = mem_funct3[1:0] == 2'b00;
    assign is_h = mem_funct3[1:0] == 2'b01;
    assign bad = is_h ? mem_ALUResult[0] : !is_b && mem_ALUResult[1:0] != 2'b00;
    assign start = state == IDLE && access && !bad;
    assign misalign = state == IDLE && access && bad;
    assign stall = !rst && (state == BUSY || start);
    assign pcsrc = mem_branch & mem_zeroFlag;
    assign branch_target = mem_branchTargetAddress;

    lsu_load_align u_align (
        .rdata  (dmem.dmem_rdata),
        .addr   (lane),
        .funct3 (f3),
        .result (aligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_wdata <= '0;
            dmem.dmem_be    <= '0;
            load_data       <= '0;
            bus_err         <= 1'b0;
            cnt             <= '0;
            lane            <= '0;
            f3              <= '0;
        end else begin
            bus_err <= 1'b0;
            if (start) begin
                state           <= BUSY;
                dmem.dmem_req   <= 1'b1;
                dmem.dmem_we    <= mem_memWrite & !mem_memRead;
                dmem.dmem_addr  <= {mem_ALUResult[31:2], 2'b00};
                dmem.dmem_wdata <= is_b ? {4{mem_readData2[7:0]}} :
                                   is_h ? {2{mem_readData2[15:0]}} : mem_readData2;
                dmem.dmem_be    <= mem_memRead ? {BE_W{1'b1}} :
                                   is_b ? 4'b0001 << mem_ALUResult[1:0] :
                                   is_h ? (mem_ALUResult[1] ? 4'b1100 : 4'b0011) : {BE_W{1'b1}};
                cnt             <= '0;
                lane            <= mem_ALUResult[1:0];
                f3              <= mem_funct3;
            end else if (state == BUSY) begin
                if (dmem.dmem_ack || cnt == 8'(MAX_WAIT - 1)) begin
                    state         <= DONE;
                    dmem.dmem_req <= 1'b0;
                    load_data     <= dmem.dmem_ack ? aligned : 32'h0;
                    bus_err       <= !dmem.dmem_ack;
                end
                cnt <= cnt + 8'd1;
            end else if (state == DONE) begin
                state     <= IDLE;
                load_data <= '0;
            end
        end
    end
endmodule
